// File: rtl/cla_pkg.sv
// Shared types and lookahead helpers for the pipelined CLA adder.
// Group width, propagate/generate pair, and 4-bit carry lookahead.
package cla_pkg;

  localparam int GRP = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic pg_t pg_combine(pg_t hi, pg_t lo);
    pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

  function automatic logic [4:1] cla4_carries(
    logic [3:0] p,
    logic [3:0] g,
    logic       c
  );
    logic [4:1] r;
    r[1] = g[0] | (p[0] & c);
    r[2] = g[1] | (p[1] & g[0])
         | (&p[1:0] & c);
    r[3] = g[2] | (p[2] & g[1])
         | (&p[2:1] & g[0])
         | (&p[2:0] & c);
    r[4] = g[3] | (p[3] & g[2])
         | (&p[3:2] & g[1])
         | (&p[3:1] & g[0])
         | (&p[3:0] & c);
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: group propagate/generate and
// the four carries out of each bit position.
import cla_pkg::*;

module cla_group4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       c,
  output logic       gp,
  output logic       gg,
  output logic [4:1] carries
);

  pg_t acc;

  always_comb begin
    acc.p = p[0];
    acc.g = g[0];
    for (int i = 1; i < 4; i++) begin
      acc = pg_combine({p[i], g[i]}, acc);
    end
    gp      = acc.p;
    gg      = acc.g;
    carries = cla4_carries(p, g, c);
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor
// with valid/ready handshake and bubble-collapsing stall.
import cla_pkg::*;

module cla_adder_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             p_all,
  output logic             g_all
);

  localparam int NG = WIDTH / GRP;

  if ((WIDTH % GRP) != 0 || WIDTH < 4 || WIDTH > 64)
  begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64");
  end

  logic             v1, v2;
  logic             ready1, ready2;
  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic             c0_in;
  logic [NG-1:0]    gp_in, gg_in;
  logic [WIDTH-1:0] c1_unused;

  logic [WIDTH-1:0] p1, g1;
  logic             c01;
  logic [NG-1:0]    gp1, gg1;

  pg_t              pre [NG];
  logic [NG-1:0]    gc;
  logic [NG-1:0]    gp2, gg2_unused;
  logic [WIDTH:0]   carry;

  assign ready2    = !v2 | out_ready;
  assign ready1    = !v1 | ready2;
  assign in_ready  = ready1;
  assign out_valid = v2;

  assign b_eff = sub ? ~b : b;
  assign c0_in = sub | cin;
  assign p_in  = a ^ b_eff;
  assign g_in  = a & b_eff;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla_group4 u_grp (
      .p       (p_in[GRP*k +: GRP]),
      .g       (g_in[GRP*k +: GRP]),
      .c       (1'b0),
      .gp      (gp_in[k]),
      .gg      (gg_in[k]),
      .carries (c1_unused[GRP*k +: GRP])
    );
  end

  // Log-depth prefix over groups; descending k keeps lower terms at the old level.
  always_comb begin
    for (int k = 0; k < NG; k++) begin
      pre[k].p = gp1[k];
      pre[k].g = gg1[k];
    end
    for (int d = 1; d < NG; d = d * 2) begin
      for (int k = NG - 1; k >= d; k--) begin
        pre[k] = pg_combine(pre[k], pre[k-d]);
      end
    end
  end

  always_comb begin
    gc    = '0;
    gc[0] = c01;
    for (int k = 1; k < NG; k++) begin
      gc[k] = pre[k-1].g | (pre[k-1].p & c01);
    end
  end

  assign carry[0] = c01;

  for (genvar k = 0; k < NG; k++) begin : g_s2
    cla_group4 u_grp (
      .p       (p1[GRP*k +: GRP]),
      .g       (g1[GRP*k +: GRP]),
      .c       (gc[k]),
      .gp      (gp2[k]),
      .gg      (gg2_unused[k]),
      .carries (carry[GRP*k+1 +: GRP])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ready1) v1 <= in_valid;
      if (ready2) v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (ready1 && in_valid) begin
      p1  <= p_in;
      g1  <= g_in;
      c01 <= c0_in;
      gp1 <= gp_in;
      gg1 <= gg_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      p_all <= 1'b0;
      g_all <= 1'b0;
    end else if (ready2 && v1) begin
      sum   <= p1 ^ carry[WIDTH-1:0];
      cout  <= carry[WIDTH];
      ovf   <= carry[WIDTH] ^ carry[WIDTH-1];
      p_all <= &gp2;
      g_all <= pre[NG-1].g;
    end
  end

endmodule
